// File: rtl/seg7_seconds_monitor.sv
// Seven-segment seconds display monitor: resamples the segment lines,
// decodes the digit, checks the 0..9 count and measures tick period.
module seg7_seconds_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       seg_in,
  output logic [3:0]       digit,
  output logic             digit_valid,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             seq_error,
  output logic             pattern_err,
  output logic             locked
);

  localparam int SC_W =
    (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [SC_W-1:0] SC_MAX =
    SC_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    LOCKED
  } state_t;

  logic [6:0]       s1;
  logic [6:0]       s2;
  logic [6:0]       cand;
  logic [6:0]       acc_pat;
  logic [SC_W-1:0]  stable_cnt;
  logic [CNT_W-1:0] tick;
  logic             accept;

  state_t           state;
  state_t           state_nxt;
  logic [3:0]       digit_nxt;
  logic [CNT_W-1:0] period_nxt;
  logic             dv_nxt;
  logic             pv_nxt;
  logic             se_nxt;
  logic             pe_nxt;

  logic [3:0]       dec_val;
  logic             dec_ok;
  logic             dec_blank;
  logic [3:0]       succ;

  // A pattern is taken once it has been held long enough and differs
  // from the one already taken.
  assign accept = (s2 == cand) &&
                  (stable_cnt == SC_MAX) &&
                  (cand != acc_pat);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= 7'h00;
      s2         <= 7'h00;
      cand       <= 7'h00;
      acc_pat    <= 7'h00;
      stable_cnt <= '0;
    end else begin
      s1 <= seg_in;
      s2 <= s1;
      if (s2 != cand) begin
        cand       <= s2;
        stable_cnt <= '0;
      end else begin
        if (stable_cnt != SC_MAX)
          stable_cnt <= stable_cnt + SC_W'(1);
        if (accept)
          acc_pat <= cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      tick <= '0;
    else if (accept)
      tick <= CNT_W'(1);
    else if (tick != '1)
      tick <= tick + CNT_W'(1);
  end

  always_comb begin
    dec_val   = 4'd0;
    dec_ok    = 1'b1;
    dec_blank = 1'b0;
    case (cand)
      7'h3F: dec_val = 4'd0;
      7'h06: dec_val = 4'd1;
      7'h5B: dec_val = 4'd2;
      7'h4F: dec_val = 4'd3;
      7'h66: dec_val = 4'd4;
      7'h6D: dec_val = 4'd5;
      7'h7D: dec_val = 4'd6;
      7'h07: dec_val = 4'd7;
      7'h7F: dec_val = 4'd8;
      7'h6F: dec_val = 4'd9;
      7'h00: begin
        dec_ok    = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_ok = 1'b0;
    endcase
  end

  assign succ = (digit == 4'd9) ? 4'd0 : digit + 4'd1;

  always_comb begin
    state_nxt  = state;
    digit_nxt  = digit;
    period_nxt = period;
    dv_nxt     = 1'b0;
    pv_nxt     = 1'b0;
    se_nxt     = 1'b0;
    pe_nxt     = 1'b0;
    if (accept) begin
      if (dec_blank) begin
        state_nxt = IDLE;
      end else if (!dec_ok) begin
        pe_nxt    = 1'b1;
        state_nxt = IDLE;
      end else begin
        digit_nxt = dec_val;
        case (state)
          IDLE: state_nxt = FIRST;
          FIRST: begin
            if (dec_val == succ) begin
              dv_nxt    = 1'b1;
              state_nxt = LOCKED;
            end else begin
              se_nxt    = 1'b1;
              state_nxt = FIRST;
            end
          end
          LOCKED: begin
            if (dec_val == succ) begin
              dv_nxt     = 1'b1;
              pv_nxt     = 1'b1;
              period_nxt = tick;
              state_nxt  = LOCKED;
            end else begin
              se_nxt    = 1'b1;
              state_nxt = FIRST;
            end
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      digit        <= 4'd0;
      period       <= '0;
      digit_valid  <= 1'b0;
      period_valid <= 1'b0;
      seq_error    <= 1'b0;
      pattern_err  <= 1'b0;
    end else begin
      state        <= state_nxt;
      digit        <= digit_nxt;
      period       <= period_nxt;
      digit_valid  <= dv_nxt;
      period_valid <= pv_nxt;
      seq_error    <= se_nxt;
      pattern_err  <= pe_nxt;
    end
  end

  assign locked = (state == LOCKED);

endmodule

// File: tb/tb_seg7_seconds_monitor.sv
// Bench for seg7_seconds_monitor: run-length behavioural model checked
// every cycle, plus directed literal expectations.
module tb_seg7_seconds_monitor;

  localparam int SC = 4;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    seg_in = 7'h00;
  logic [3:0]    digit;
  logic          digit_valid;
  logic [CW-1:0] period;
  logic          period_valid;
  logic          seq_error;
  logic          pattern_err;
  logic          locked;

  seg7_seconds_monitor #(
    .STABLE_CYCLES(SC),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .seg_in(seg_in),
    .digit(digit),
    .digit_valid(digit_valid),
    .period(period),
    .period_valid(period_valid),
    .seq_error(seq_error),
    .pattern_err(pattern_err),
    .locked(locked)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int checks = 0;
  int failures = 0;

  // model state
  logic [6:0]    q[$];
  logic [6:0]    run_val;
  logic [6:0]    m_acc;
  logic [6:0]    x;
  int            run_len;
  int            m_mode;
  int            d;
  logic [3:0]    m_digit;
  logic [CW-1:0] m_period;
  logic          m_dv, m_pv, m_se, m_pe;
  longint        cyc = 0;
  longint        base = 0;
  longint        tk;
  bit            model_on = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q = '{7'h00, 7'h00};
      run_val = 7'h00;
      run_len = 1;
      m_acc = 7'h00;
      m_mode = 0;
      m_digit = 4'd0;
      m_period = '0;
      {m_dv, m_pv, m_se, m_pe} = 4'b0;
      base = cyc + 1;
      model_on = 1'b1;
    end else if (model_on) begin
      {m_dv, m_pv, m_se, m_pe} = 4'b0;
      x = q.pop_front();
      q.push_back(seg_in);
      if (x == run_val) begin
        if (run_len < 1000000) run_len++;
      end else begin
        run_val = x;
        run_len = 1;
      end
      tk = cyc - base;
      if (tk > ((64'sd1 << CW) - 1)) tk = (64'sd1 << CW) - 1;
      if (run_len == SC + 1 && run_val != m_acc) begin
        m_acc = run_val;
        base = cyc;
        d = -1;
        for (int i = 0; i < 10; i++)
          if (pats[i] == run_val) d = i;
        if (run_val == 7'h00) begin
          m_mode = 0;
        end else if (d < 0) begin
          m_pe = 1'b1;
          m_mode = 0;
        end else if (m_mode == 0) begin
          m_digit = 4'(d);
          m_mode = 1;
        end else if (d == (int'(m_digit) + 1) % 10) begin
          m_dv = 1'b1;
          if (m_mode == 2) begin
            m_pv = 1'b1;
            m_period = CW'(tk);
          end
          m_mode = 2;
          m_digit = 4'(d);
        end else begin
          m_se = 1'b1;
          m_digit = 4'(d);
          m_mode = 1;
        end
      end
    end
  end

  logic [32:0] act_v, exp_v;

  always @(negedge clk) begin
    if (model_on) begin
      act_v = {digit, digit_valid, period, period_valid,
               seq_error, pattern_err, locked};
      exp_v = {m_digit, m_dv, m_period, m_pv,
               m_se, m_pe, (m_mode == 2)};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model_cmp t=%0t actual=%h required=%h",
                 $time, act_v, exp_v);
      end
    end
  end

  int dv_n = 0, pv_n = 0, se_n = 0, pe_n = 0;

  always @(posedge clk) begin
    #1;
    if (digit_valid === 1'b1) dv_n++;
    if (period_valid === 1'b1) pv_n++;
    if (seq_error === 1'b1) se_n++;
    if (pattern_err === 1'b1) pe_n++;
  end

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic hold(input logic [6:0] p, input int n);
    seg_in = p;
    repeat (n) @(negedge clk);
  endtask

  int pv0, dv0, se0;

  initial begin
    reset = 1'b1;
    seg_in = 7'h3F;
    repeat (2) @(negedge clk);
    chk("rst_digit", digit, 0);
    chk("rst_period", period, 0);
    chk("rst_flags", {digit_valid, period_valid, seq_error,
                      pattern_err, locked}, 0);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    chk("first_digit", digit, 0);
    chk("first_unlocked", locked, 0);
    chk("first_no_dv", dv_n, 0);
    hold(7'h3F, 992);

    hold(7'h06, 1000);
    chk("lock_at_1", locked, 1);
    chk("dv_at_1", dv_n, 1);
    chk("no_pv_at_1", pv_n, 0);
    hold(7'h5B, 1000);
    chk("period_at_2", period, 1000);
    chk("pv_at_2", pv_n, 1);
    for (int i = 3; i < 10; i++) hold(pats[i], 1000);
    hold(7'h3F, 1000);
    chk("wrap_digit", digit, 0);
    chk("wrap_dv", dv_n, 10);
    chk("wrap_pv", pv_n, 9);
    chk("wrap_no_se", se_n, 0);
    chk("wrap_locked", locked, 1);

    for (int i = 1; i < 5; i++) hold(pats[i], 1000);
    hold(7'h7D, 1000);
    chk("skip_se", se_n, 1);
    chk("skip_digit", digit, 6);
    chk("skip_unlocked", locked, 0);
    pv0 = pv_n;
    dv0 = dv_n;
    hold(7'h07, 1000);
    chk("relock_digit", digit, 7);
    chk("relock_locked", locked, 1);
    chk("relock_no_pv", pv_n, pv0);
    chk("relock_dv", dv_n, dv0 + 1);
    hold(7'h7F, 1000);
    chk("relock_period", period, 1000);

    hold(7'h6F, 500);
    hold(7'h7F, 3);
    hold(7'h6F, 497);
    dv0 = dv_n;
    se0 = se_n;
    hold(7'h3F, 1000);
    chk("glitch_period", period, 1000);
    chk("glitch_dv", dv_n, dv0 + 1);
    chk("glitch_no_se", se_n, se0);
    hold(7'h7F, SC + 1);
    hold(7'h49, 100);
    chk("short_hold_se", se_n, se0 + 1);
    chk("illegal_pe", pe_n, 1);
    chk("illegal_digit", digit, 8);
    chk("illegal_unlocked", locked, 0);
    hold(7'h00, 100);
    chk("blank_no_pe", pe_n, 1);
    chk("blank_digit", digit, 8);

    hold(7'h3F, 100);
    hold(7'h06, 100);
    hold(7'h5B, 100);
    chk("pre_rst_locked", locked, 1);
    chk("pre_rst_period", period, 100);
    hold(7'h4F, 3);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_digit", digit, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_locked", locked, 0);
    hold(7'h4F, 100);
    chk("post_rst_digit", digit, 3);
    chk("post_rst_unlocked", locked, 0);
    hold(7'h66, 100);
    chk("post_rst_locked", locked, 1);
    chk("post_rst_period", period, 0);
    pv0 = pv_n;
    hold(7'h6D, 100);
    chk("post_rst_pv", pv_n, pv0 + 1);
    chk("post_rst_period2", period, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
